// File: rtl/csr_pkg.sv
// Shared CSR addresses, mstatus bit positions, IRQ cause codes and sequencer states
// for the trap/mret sequencer and the CSR file that sits beside it.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] IRQ_MSI = 32'd3;
    localparam logic [31:0] IRQ_MTI = 32'd7;
    localparam logic [31:0] IRQ_MEI = 32'd11;

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_TVAL,
        T_STATUS,
        T_VEC,
        M_STATUS,
        M_EPC
    } seq_state_t;

    // Vectored mode (mtvec[1:0] == 1) only offsets interrupts; 4*cause[30:0] wraps mod 2^32.
    function automatic logic [31:0] trap_vector(input logic [31:0] mtvec, input logic [31:0] cause);
        logic [31:0] base;
        base = mtvec & ~32'h3;
        if (mtvec[1:0] == 2'b01 && cause[31])
            return base + {cause[29:0], 2'b00};
        return base;
    endfunction

endpackage

// File: rtl/csr_trap_seq.sv
// Trap entry / mret sequencer: walks the CSR write port through the machine-mode
// trap and return sequences and arbitrates core CSR-instruction access.
//
// state    | meaning
// IDLE     | accept trap > mret > core CSR access
// T_EPC    | write mepc = pc & ~3
// T_CAUSE  | write mcause
// T_TVAL   | write mtval
// T_STATUS | mstatus: MPIE <= MIE, MIE <= 0
// T_VEC    | read mtvec, redirect fetch to handler
// M_STATUS | mstatus: MIE <= MPIE, MPIE <= 1
// M_EPC    | read mepc, redirect fetch to return address
module csr_trap_seq
    import csr_pkg::*;
(
    input  logic        ctrl_clk,
    input  logic        ctrl_reset_n,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_req,
    input  logic        insn_req,
    input  logic [11:0] insn_addr,
    input  logic [31:0] insn_wdata,
    input  logic        insn_wen,
    output logic        insn_gnt,
    output logic [31:0] insn_rdata,
    output logic        req_ack,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_wen,
    input  logic [31:0] csr_rdata
);

    seq_state_t  state;
    logic [31:0] cause_q;
    logic [31:0] pc_q;
    logic [31:0] tval_q;
    logic        in_idle;

    // Qualify with reset so the combinational handshakes stay low while reset is held.
    assign in_idle  = (state == IDLE) && ctrl_reset_n;
    assign req_ack  = in_idle && (trap_req || mret_req);
    assign insn_gnt = in_idle && insn_req && !trap_req && !mret_req;
    assign busy     = (state != IDLE);

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state   <= IDLE;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_req) begin
                        cause_q <= trap_cause;
                        pc_q    <= trap_pc;
                        tval_q  <= trap_tval;
                        state   <= T_EPC;
                    end else if (mret_req) begin
                        state <= M_STATUS;
                    end
                end
                T_EPC:    state <= T_CAUSE;
                T_CAUSE:  state <= T_TVAL;
                T_TVAL:   state <= T_STATUS;
                T_STATUS: state <= T_VEC;
                T_VEC:    state <= IDLE;
                M_STATUS: state <= M_EPC;
                M_EPC:    state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // The CSR file reads combinationally, so read-modify-write fits in one state.
    always_comb begin
        csr_addr       = '0;
        csr_wdata      = '0;
        csr_wen        = 1'b0;
        insn_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: begin
                if (insn_gnt) begin
                    csr_addr   = insn_addr;
                    csr_wdata  = insn_wdata;
                    csr_wen    = insn_wen;
                    insn_rdata = csr_rdata;
                end
            end
            T_EPC: begin
                csr_addr  = CSR_MEPC;
                csr_wdata = pc_q & ~32'h3;
                csr_wen   = 1'b1;
            end
            T_CAUSE: begin
                csr_addr  = CSR_MCAUSE;
                csr_wdata = cause_q;
                csr_wen   = 1'b1;
            end
            T_TVAL: begin
                csr_addr  = CSR_MTVAL;
                csr_wdata = tval_q;
                csr_wen   = 1'b1;
            end
            T_STATUS: begin
                csr_addr                = CSR_MSTATUS;
                csr_wdata               = csr_rdata;
                csr_wdata[MSTATUS_MPIE] = csr_rdata[MSTATUS_MIE];
                csr_wdata[MSTATUS_MIE]  = 1'b0;
                csr_wen                 = 1'b1;
            end
            T_VEC: begin
                csr_addr       = CSR_MTVEC;
                redirect_valid = 1'b1;
                redirect_pc    = trap_vector(csr_rdata, cause_q);
            end
            M_STATUS: begin
                csr_addr                = CSR_MSTATUS;
                csr_wdata               = csr_rdata;
                csr_wdata[MSTATUS_MIE]  = csr_rdata[MSTATUS_MPIE];
                csr_wdata[MSTATUS_MPIE] = 1'b1;
                csr_wen                 = 1'b1;
            end
            M_EPC: begin
                csr_addr       = CSR_MEPC;
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed bench for csr_trap_seq with a small CSR-file model on the write/read port.
module tb_csr_trap_seq;
    import csr_pkg::*;

    logic        ctrl_clk;
    logic        ctrl_reset_n;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_req;
    logic        insn_req;
    logic [11:0] insn_addr;
    logic [31:0] insn_wdata;
    logic        insn_wen;
    logic        insn_gnt;
    logic [31:0] insn_rdata;
    logic        req_ack;
    logic        busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_wen;
    logic [31:0] csr_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        pre_en;
    logic [31:0] pre_mstatus, pre_mtvec;
    int          wr_mtval_cnt, wr_mstatus_cnt, redir_cnt;
    int          snap_mtval, snap_mstatus, snap_redir;

    csr_trap_seq dut (
        .ctrl_clk       (ctrl_clk),
        .ctrl_reset_n   (ctrl_reset_n),
        .trap_req       (trap_req),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .trap_tval      (trap_tval),
        .mret_req       (mret_req),
        .insn_req       (insn_req),
        .insn_addr      (insn_addr),
        .insn_wdata     (insn_wdata),
        .insn_wen       (insn_wen),
        .insn_gnt       (insn_gnt),
        .insn_rdata     (insn_rdata),
        .req_ack        (req_ack),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_wen        (csr_wen),
        .csr_rdata      (csr_rdata)
    );

    initial ctrl_clk = 1'b0;
    always #5 ctrl_clk = ~ctrl_clk;

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = m_mstatus;
            CSR_MTVEC:   csr_rdata = m_mtvec;
            CSR_MEPC:    csr_rdata = m_mepc;
            CSR_MCAUSE:  csr_rdata = m_mcause;
            CSR_MTVAL:   csr_rdata = m_mtval;
            default:     csr_rdata = '0;
        endcase
    end

    always @(posedge ctrl_clk) begin
        if (pre_en) begin
            m_mstatus      <= pre_mstatus;
            m_mtvec        <= pre_mtvec;
            m_mepc         <= '0;
            m_mcause       <= '0;
            m_mtval        <= '0;
            wr_mtval_cnt   <= 0;
            wr_mstatus_cnt <= 0;
            redir_cnt      <= 0;
        end else begin
            if (csr_wen) begin
                case (csr_addr)
                    CSR_MSTATUS: begin m_mstatus <= csr_wdata; wr_mstatus_cnt <= wr_mstatus_cnt + 1; end
                    CSR_MTVEC:   m_mtvec <= csr_wdata;
                    CSR_MEPC:    m_mepc <= csr_wdata;
                    CSR_MCAUSE:  m_mcause <= csr_wdata;
                    CSR_MTVAL:   begin m_mtval <= csr_wdata; wr_mtval_cnt <= wr_mtval_cnt + 1; end
                    default: ;
                endcase
            end
            if (redirect_valid) redir_cnt <= redir_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ctrl_clk);
        #1;
    endtask

    // Drives one trap from IDLE; any mret_req held by the caller is dropped once it has been refused.
    task automatic run_trap(input string tag, input logic [31:0] cause, input logic [31:0] pc,
                            input logic [31:0] tval, input logic [31:0] exp_epc,
                            input logic [31:0] exp_status, input logic [31:0] exp_redir);
        trap_req = 1'b1; trap_cause = cause; trap_pc = pc; trap_tval = tval;
        #1;
        chk({tag, ".ack"}, {31'd0, req_ack}, 32'd1);
        chk({tag, ".ack_gnt"}, {31'd0, insn_gnt}, 32'd0);
        chk({tag, ".ack_busy"}, {31'd0, busy}, 32'd0);
        tick();
        trap_req = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
        #1;
        chk({tag, ".epc_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, ".busy_noack"}, {31'd0, req_ack}, 32'd0);
        chk({tag, ".busy_nognt"}, {31'd0, insn_gnt}, 32'd0);
        mret_req = 1'b0;
        chk({tag, ".epc_addr"}, {20'd0, csr_addr}, {20'd0, CSR_MEPC});
        chk({tag, ".epc_data"}, csr_wdata, exp_epc);
        chk({tag, ".epc_wen"}, {31'd0, csr_wen}, 32'd1);
        chk({tag, ".epc_redir"}, {31'd0, redirect_valid}, 32'd0);
        tick();
        chk({tag, ".cause_addr"}, {20'd0, csr_addr}, {20'd0, CSR_MCAUSE});
        chk({tag, ".cause_data"}, csr_wdata, cause);
        chk({tag, ".cause_wen"}, {31'd0, csr_wen}, 32'd1);
        tick();
        chk({tag, ".tval_addr"}, {20'd0, csr_addr}, {20'd0, CSR_MTVAL});
        chk({tag, ".tval_data"}, csr_wdata, tval);
        tick();
        chk({tag, ".status_addr"}, {20'd0, csr_addr}, {20'd0, CSR_MSTATUS});
        chk({tag, ".status_data"}, csr_wdata, exp_status);
        chk({tag, ".status_wen"}, {31'd0, csr_wen}, 32'd1);
        chk({tag, ".status_redir"}, {31'd0, redirect_valid}, 32'd0);
        tick();
        chk({tag, ".vec_valid"}, {31'd0, redirect_valid}, 32'd1);
        chk({tag, ".vec_pc"}, redirect_pc, exp_redir);
        chk({tag, ".vec_wen"}, {31'd0, csr_wen}, 32'd0);
        chk({tag, ".vec_addr"}, {20'd0, csr_addr}, {20'd0, CSR_MTVEC});
        tick();
        chk({tag, ".done_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".done_redir"}, {31'd0, redirect_valid}, 32'd0);
    endtask

    task automatic insn_write(input string tag, input logic [11:0] addr, input logic [31:0] data);
        insn_req = 1'b1; insn_wen = 1'b1; insn_addr = addr; insn_wdata = data;
        #1;
        chk({tag, ".gnt"}, {31'd0, insn_gnt}, 32'd1);
        chk({tag, ".wen"}, {31'd0, csr_wen}, 32'd1);
        chk({tag, ".addr"}, {20'd0, csr_addr}, {20'd0, addr});
        chk({tag, ".wdata"}, csr_wdata, data);
        tick();
        insn_req = 1'b0; insn_wen = 1'b0; insn_addr = '0; insn_wdata = '0;
    endtask

    initial begin
        ctrl_reset_n = 1'b0;
        trap_req = 1'b1; trap_cause = 32'h2; trap_pc = 32'h203; trap_tval = 32'h1;
        mret_req = 1'b1;
        insn_req = 1'b1; insn_addr = CSR_MSTATUS; insn_wdata = 32'h5; insn_wen = 1'b1;
        pre_en = 1'b1; pre_mstatus = 32'h8; pre_mtvec = 32'h100;
        #2;
        chk("rst.req_ack", {31'd0, req_ack}, 32'd0);
        chk("rst.insn_gnt", {31'd0, insn_gnt}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.csr_wen", {31'd0, csr_wen}, 32'd0);
        chk("rst.csr_addr", {20'd0, csr_addr}, 32'd0);
        chk("rst.csr_wdata", csr_wdata, 32'd0);
        chk("rst.insn_rdata", insn_rdata, 32'd0);
        chk("rst.redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst.redirect_pc", redirect_pc, 32'd0);
        tick();
        pre_en = 1'b0;
        trap_req = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
        mret_req = 1'b0;
        insn_req = 1'b0; insn_addr = '0; insn_wdata = '0; insn_wen = 1'b0;
        ctrl_reset_n = 1'b1;
        #1;
        chk("idle.csr_addr", {20'd0, csr_addr}, 32'd0);
        chk("idle.csr_wen", {31'd0, csr_wen}, 32'd0);

        // Basic synchronous exception: mstatus 0x8 -> 0x80, redirect to mtvec 0x100.
        run_trap("trap1", 32'h2, 32'h203, 32'hDEAD, 32'h200, 32'h80, 32'h100);
        chk("trap1.mstatus_model", m_mstatus, 32'h80);
        chk("trap1.mtval_model", m_mtval, 32'hDEAD);

        // Contention: trap wins over mret and insn; insn granted right after T_VEC.
        mret_req = 1'b1;
        insn_req = 1'b1; insn_addr = CSR_MTVAL; insn_wen = 1'b0;
        run_trap("cont", 32'h2, 32'h10, 32'h55, 32'h10, 32'h0, 32'h100);
        chk("cont.after_gnt", {31'd0, insn_gnt}, 32'd1);
        chk("cont.after_addr", {20'd0, csr_addr}, {20'd0, CSR_MTVAL});
        chk("cont.after_rdata", insn_rdata, 32'h55);
        chk("cont.after_wen", {31'd0, csr_wen}, 32'd0);
        insn_req = 1'b0; insn_addr = '0;
        #1;
        chk("cont.drop_rdata", insn_rdata, 32'd0);

        // Vectored mtvec: interrupt offsets by 4*code, exception does not.
        insn_write("wr_mtvec", CSR_MTVEC, 32'h101);
        run_trap("vec_irq", 32'h8000_0007, 32'h500, 32'h0, 32'h500, 32'h0, 32'h11C);
        run_trap("vec_exc", 32'h7, 32'h502, 32'h77, 32'h500, 32'h0, 32'h100);

        // mret: mstatus 0x80 -> 0x88, return to mepc 0x400.
        insn_write("wr_mepc", CSR_MEPC, 32'h400);
        insn_write("wr_mstatus", CSR_MSTATUS, 32'h80);
        mret_req = 1'b1;
        #1;
        chk("mret.ack", {31'd0, req_ack}, 32'd1);
        tick();
        mret_req = 1'b0;
        #1;
        chk("mret.busy", {31'd0, busy}, 32'd1);
        chk("mret.st_addr", {20'd0, csr_addr}, {20'd0, CSR_MSTATUS});
        chk("mret.st_data", csr_wdata, 32'h88);
        chk("mret.st_wen", {31'd0, csr_wen}, 32'd1);
        chk("mret.st_redir", {31'd0, redirect_valid}, 32'd0);
        tick();
        trap_req = 1'b1; trap_cause = 32'h3; trap_pc = 32'h600; trap_tval = 32'h99;
        #1;
        chk("mret.epc_valid", {31'd0, redirect_valid}, 32'd1);
        chk("mret.epc_pc", redirect_pc, 32'h400);
        chk("mret.epc_wen", {31'd0, csr_wen}, 32'd0);
        chk("mret.epc_noack", {31'd0, req_ack}, 32'd0);
        tick();
        chk("b2b.ack", {31'd0, req_ack}, 32'd1);
        chk("b2b.busy", {31'd0, busy}, 32'd0);
        chk("mret.mstatus_model", m_mstatus, 32'h88);

        // Reset pulse during T_CAUSE abandons the trap.
        tick();
        trap_req = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
        tick();
        chk("rstmid.in_cause", {20'd0, csr_addr}, {20'd0, CSR_MCAUSE});
        snap_mtval = wr_mtval_cnt; snap_mstatus = wr_mstatus_cnt; snap_redir = redir_cnt;
        ctrl_reset_n = 1'b0;
        #1;
        chk("rstmid.busy", {31'd0, busy}, 32'd0);
        chk("rstmid.wen", {31'd0, csr_wen}, 32'd0);
        chk("rstmid.addr", {20'd0, csr_addr}, 32'd0);
        chk("rstmid.redir", {31'd0, redirect_valid}, 32'd0);
        #2;
        ctrl_reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rstmid.idle_busy", {31'd0, busy}, 32'd0);
            chk("rstmid.idle_wen", {31'd0, csr_wen}, 32'd0);
        end
        chk("rstmid.mtval_writes", snap_mtval, wr_mtval_cnt);
        chk("rstmid.mstatus_writes", snap_mstatus, wr_mstatus_cnt);
        chk("rstmid.redirects", snap_redir, redir_cnt);
        insn_req = 1'b1; insn_addr = CSR_MTVAL; insn_wen = 1'b0;
        #1;
        chk("resume.gnt", {31'd0, insn_gnt}, 32'd1);
        chk("resume.mtval", insn_rdata, 32'h77);
        tick();
        insn_req = 1'b0; insn_addr = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
